// File: rtl/seq_mac_arbiter.sv
// Round-robin arbiter/sequencer sharing one seq_MAC engine among R requesters; SEQ_MAC_ARB_PERF_EN adds perf counters.
// Accept->issue and MAC result->response are 1 cycle each; a response is held until its owner takes it, blocking new accepts.
module seq_mac_arbiter #(
   parameter int R         = 4,
   parameter int M         = 2,
   parameter int N         = 2,
   parameter int K         = 2,
   parameter int MAX_WIDTH = 16,
   parameter int P         = 2,
   localparam int BW       = $clog2(MAX_WIDTH / P) + 1,
   localparam int AW       = M * K * MAX_WIDTH,
   localparam int BBW      = K * N * MAX_WIDTH,
   localparam int CW       = M * N * 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
`ifdef SEQ_MAC_ARB_PERF_EN
   output logic [31:0]       perf_jobs_o,
   output logic [31:0]       perf_busy_o,
`endif
   input  logic [R-1:0]      req_valid_i,
   output logic [R-1:0]      req_ready_o,
   input  logic [R*AW-1:0]   req_a_i,
   input  logic [R*BBW-1:0]  req_b_i,
   input  logic [R*CW-1:0]   req_c_i,
   input  logic [R*BW-1:0]   req_bsa_i,
   input  logic [R*BW-1:0]   req_bsb_i,
   output logic [R-1:0]      rsp_valid_o,
   input  logic [R-1:0]      rsp_ready_i,
   output logic [CW-1:0]     rsp_d_o,
   output logic              rsp_err_o,
   output logic              mac_valid_o,
   input  logic              mac_ready_i,
   output logic [AW-1:0]     mac_a_o,
   output logic [BBW-1:0]    mac_b_o,
   output logic [CW-1:0]     mac_c_o,
   output logic [BW-1:0]     mac_bsa_o,
   output logic [BW-1:0]     mac_bsb_o,
   input  logic              mac_valid_i,
   output logic              mac_ready_o,
   input  logic [CW-1:0]     mac_d_i
);

   localparam int PW = $clog2(R);
   localparam logic [BW-1:0] BS_MAX = BW'(MAX_WIDTH / P);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [PW-1:0]  ptr, owner, grant;
   logic [R-1:0]   rot;
   logic           found, legal, accept, rsp_done;
   logic [AW-1:0]  sel_a, a_q;
   logic [BBW-1:0] sel_b, b_q;
   logic [CW-1:0]  sel_c, c_q, d_q;
   logic [BW-1:0]  sel_bsa, sel_bsb, bsa_q, bsb_q;
   logic           err_q;

   // Rotate the request vector so that bit 0 is the requester at ptr; the lowest set bit wins.
   always_comb begin
      int off;
      off   = 0;
      rot   = R'({req_valid_i, req_valid_i} >> ptr);
      found = |req_valid_i;
      for (int j = R - 1; j >= 0; j--) begin
         if (rot[j]) off = j;
      end
      grant = PW'((int'(ptr) + off) % R);
   end

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_c   = '0;
      sel_bsa = '0;
      sel_bsb = '0;
      for (int r = 0; r < R; r++) begin
         if (grant == PW'(r)) begin
            sel_a   = req_a_i[r*AW +: AW];
            sel_b   = req_b_i[r*BBW +: BBW];
            sel_c   = req_c_i[r*CW +: CW];
            sel_bsa = req_bsa_i[r*BW +: BW];
            sel_bsb = req_bsb_i[r*BW +: BW];
         end
      end
   end

   assign legal    = (sel_bsa != '0) && (sel_bsa <= BS_MAX) &&
                     (sel_bsb != '0) && (sel_bsb <= BS_MAX);
   assign accept   = (state == IDLE) && found;
   assign rsp_done = (state == RESP) && rsp_ready_i[owner];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ready_o = '0;
      rsp_valid_o = '0;
      mac_valid_o = 1'b0;
      mac_ready_o = 1'b0;
      case (state)
         IDLE: begin
            for (int r = 0; r < R; r++) begin
               req_ready_o[r] = found && (grant == PW'(r));
            end
            if (found) state_nxt = legal ? ISSUE : RESP;
         end
         ISSUE: begin
            mac_valid_o = 1'b1;
            if (mac_ready_i) state_nxt = WAIT;
         end
         WAIT: begin
            mac_ready_o = 1'b1;
            if (mac_valid_i) state_nxt = RESP;
         end
         RESP: begin
            for (int r = 0; r < R; r++) begin
               rsp_valid_o[r] = (owner == PW'(r));
            end
            if (rsp_ready_i[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An illegal job skips the MAC and returns its own accumulator init with the error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr   <= '0;
         owner <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         bsa_q <= '0;
         bsb_q <= '0;
         d_q   <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            c_q   <= sel_c;
            bsa_q <= sel_bsa;
            bsb_q <= sel_bsb;
            owner <= grant;
            ptr   <= (grant == PW'(R - 1)) ? '0 : grant + 1'b1;
            if (!legal) begin
               err_q <= 1'b1;
               d_q   <= sel_c;
            end
         end
         if ((state == WAIT) && mac_valid_i) begin
            d_q   <= mac_d_i;
            err_q <= 1'b0;
         end
      end
   end

   assign mac_a_o   = a_q;
   assign mac_b_o   = b_q;
   assign mac_c_o   = c_q;
   assign mac_bsa_o = bsa_q;
   assign mac_bsb_o = bsb_q;
   assign rsp_d_o   = d_q;
   assign rsp_err_o = err_q;

`ifdef SEQ_MAC_ARB_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_jobs_o <= '0;
         perf_busy_o <= '0;
      end else begin
         if (rsp_done && (perf_jobs_o != '1)) perf_jobs_o <= perf_jobs_o + 32'd1;
         if ((state != IDLE) && (perf_busy_o != '1)) perf_busy_o <= perf_busy_o + 32'd1;
      end
   end
`else
   // Job completion is otherwise only visible through the response handshake.
   logic unused_done;
   assign unused_done = rsp_done;
`endif

   ap_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(req_ready_o));

   ap_issue_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mac_valid_o && !mac_ready_i) |=> (mac_valid_o && $stable(mac_a_o) && $stable(mac_b_o) &&
                                         $stable(mac_c_o) && $stable(mac_bsa_o) && $stable(mac_bsb_o)));

endmodule

// File: tb/tb_seq_mac_arbiter.sv
// Bench for seq_mac_arbiter: grant-order table, hand-written corner sequences and randomized jobs vs a behavioural model.
module tb_seq_mac_arbiter;

   localparam int R   = 4;
   localparam int M   = 2;
   localparam int N   = 2;
   localparam int K   = 2;
   localparam int W   = 16;
   localparam int P   = 2;
   localparam int BW  = $clog2(W / P) + 1;
   localparam int AW  = M * K * W;
   localparam int BBW = K * N * W;
   localparam int CW  = M * N * 32;
   localparam int SBW = R * BW;
   localparam int BSMAX = W / P;

   logic              clk_i, rst_ni;
   logic [R-1:0]      req_valid_i, req_ready_o;
   logic [R*AW-1:0]   req_a_i;
   logic [R*BBW-1:0]  req_b_i;
   logic [R*CW-1:0]   req_c_i;
   logic [SBW-1:0]    req_bsa_i, req_bsb_i;
   logic [R-1:0]      rsp_valid_o, rsp_ready_i;
   logic [CW-1:0]     rsp_d_o;
   logic              rsp_err_o;
   logic              mac_valid_o, mac_ready_i;
   logic [AW-1:0]     mac_a_o;
   logic [BBW-1:0]    mac_b_o;
   logic [CW-1:0]     mac_c_o;
   logic [BW-1:0]     mac_bsa_o, mac_bsb_o;
   logic              mac_valid_i, mac_ready_o;
   logic [CW-1:0]     mac_d_i;

   seq_mac_arbiter #(.R(R), .M(M), .N(N), .K(K), .MAX_WIDTH(W), .P(P)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
      .req_bsa_i(req_bsa_i), .req_bsb_i(req_bsb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_d_o(rsp_d_o), .rsp_err_o(rsp_err_o),
      .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
      .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
      .mac_bsa_o(mac_bsa_o), .mac_bsb_o(mac_bsb_o),
      .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_d_i(mac_d_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [R-1:0]  mask;
      logic [BW-1:0] bsa;
      logic [BW-1:0] bsb;
      logic [R-1:0]  rdy;
      logic          err;
   } vec_t;

   vec_t           tbl[12];
   logic [AW-1:0]  job_a[R];
   logic [BBW-1:0] job_b[R];
   logic [CW-1:0]  job_c[R];
   int n_chk  = 0;
   int n_pass = 0;
   int m_ptr  = 0;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // D = C + A*B over signed operands, 32-bit wrap-around accumulation.
   function automatic logic [CW-1:0] matmul(input logic [AW-1:0] a, input logic [BBW-1:0] b,
                                            input logic [CW-1:0] c);
      logic [CW-1:0] d;
      int acc;
      d = '0;
      for (int m = 0; m < M; m++) begin
         for (int n = 0; n < N; n++) begin
            acc = int'(c[(m*N+n)*32 +: 32]);
            for (int k = 0; k < K; k++) begin
               acc = acc + int'($signed(a[(m*K+k)*W +: W])) * int'($signed(b[(k*N+n)*W +: W]));
            end
            d[(m*N+n)*32 +: 32] = acc;
         end
      end
      return d;
   endfunction

   function automatic int model_grant(input logic [R-1:0] mask, input int ptr);
      int mi, j;
      mi = int'(mask);
      for (int i = 0; i < R; i++) begin
         j = (ptr + i) % R;
         if (((mi >> j) & 1) == 1) return j;
      end
      return 0;
   endfunction

   function automatic logic bs_illegal(input logic [BW-1:0] bs);
      return (int'(bs) < 1) || (int'(bs) > BSMAX);
   endfunction

   task automatic rand_ops();
      for (int r = 0; r < R; r++) begin
         job_a[r] = {$urandom, $urandom};
         job_b[r] = {$urandom, $urandom};
         job_c[r] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic drive_ops(input logic [BW-1:0] bsa, input logic [BW-1:0] bsb);
      for (int r = 0; r < R; r++) begin
         req_a_i[r*AW +: AW]   = job_a[r];
         req_b_i[r*BBW +: BBW] = job_b[r];
         req_c_i[r*CW +: CW]   = job_c[r];
         req_bsa_i[r*BW +: BW] = bsa;
         req_bsb_i[r*BW +: BW] = bsb;
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < R * AW / 32; i++) req_a_i[i*32 +: 32] = $urandom;
      for (int i = 0; i < R * BBW / 32; i++) req_b_i[i*32 +: 32] = $urandom;
      for (int i = 0; i < R * CW / 32; i++) req_c_i[i*32 +: 32] = $urandom;
      req_bsa_i = SBW'($urandom);
      req_bsb_i = SBW'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req_ready"}, CW'(req_ready_o), '0);
      chk({tag, "_rsp_valid"}, CW'(rsp_valid_o), '0);
      chk({tag, "_rsp_d"}, rsp_d_o, '0);
      chk({tag, "_rsp_err"}, CW'(rsp_err_o), '0);
      chk({tag, "_mac_valid"}, CW'(mac_valid_o), '0);
      chk({tag, "_mac_ready"}, CW'(mac_ready_o), '0);
      chk({tag, "_mac_ab"}, CW'({mac_a_o, mac_b_o}), '0);
      chk({tag, "_mac_c"}, mac_c_o, '0);
      chk({tag, "_mac_bs"}, CW'({mac_bsa_o, mac_bsb_o}), '0);
   endtask

   // Entered just after a falling edge with the DUT idle; leaves it the same way.
   task automatic run_job(input logic [R-1:0] mask, input logic [BW-1:0] bsa, input logic [BW-1:0] bsb,
                          input logic [R-1:0] exp_rdy, input logic exp_err,
                          input int issue_stall, input int wait_lat, input int rsp_stall);
      int g;
      logic [CW-1:0] exp_d, mac_res;
      g = 0;
      for (int r = 0; r < R; r++) if (((int'(exp_rdy) >> r) & 1) == 1) g = r;
      exp_d = exp_err ? job_c[g] : matmul(job_a[g], job_b[g], job_c[g]);
      drive_ops(bsa, bsb);
      req_valid_i = mask;
      rsp_ready_i = '0;
      #1;
      chk("grant", CW'(req_ready_o), CW'(exp_rdy));
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = '1;
      scramble();
      #1;
      chk("busy_no_ready", CW'(req_ready_o), '0);
      if (exp_err) begin
         chk("err_no_issue", CW'(mac_valid_o), '0);
      end else begin
         chk("issue_t1", CW'(mac_valid_o), CW'(1));
         chk("rsp_quiet", CW'(rsp_valid_o), '0);
         mac_valid_i = 1'b1;
         mac_d_i = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < issue_stall; i++) begin
            chk("stall_a", CW'(mac_a_o), CW'(job_a[g]));
            chk("stall_c", mac_c_o, job_c[g]);
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
         end
         chk("issue_hold", CW'(mac_valid_o), CW'(1));
         chk("issue_ab", CW'({mac_a_o, mac_b_o}), CW'({job_a[g], job_b[g]}));
         chk("issue_c", mac_c_o, job_c[g]);
         chk("issue_bs", CW'({mac_bsa_o, mac_bsb_o}), CW'({bsa, bsb}));
         mac_res = matmul(mac_a_o, mac_b_o, mac_c_o);
         mac_valid_i = 1'b0;
         mac_ready_i = 1'b1;
         @(posedge clk_i);
         @(negedge clk_i);
         mac_ready_i = 1'b0;
         #1;
         chk("wait_no_issue", CW'(mac_valid_o), '0);
         chk("wait_ready", CW'(mac_ready_o), CW'(1));
         for (int i = 0; i < wait_lat; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
            chk("wait_rsp_quiet", CW'(rsp_valid_o), '0);
         end
         mac_valid_i = 1'b1;
         mac_d_i = mac_res;
         @(posedge clk_i);
         @(negedge clk_i);
         mac_d_i = {$urandom, $urandom, $urandom, $urandom};
         #1;
      end
      chk("rsp_valid", CW'(rsp_valid_o), CW'(exp_rdy));
      chk("rsp_err", CW'(rsp_err_o), CW'(exp_err));
      chk("rsp_d", rsp_d_o, exp_d);
      chk("rsp_mac_ready", CW'(mac_ready_o), '0);
      rsp_ready_i = ~exp_rdy;
      mac_valid_i = 1'b1;
      for (int i = 0; i < rsp_stall; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         #1;
         chk("bp_valid", CW'(rsp_valid_o), CW'(exp_rdy));
         chk("bp_d", rsp_d_o, exp_d);
         chk("bp_quiet", CW'({mac_valid_o, req_ready_o}), '0);
      end
      rsp_ready_i = '1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = '0;
      req_valid_i = '0;
      mac_valid_i = 1'b0;
      #1;
      chk("rsp_done", CW'(rsp_valid_o), '0);
      chk("rsp_d_hold", rsp_d_o, exp_d);
      m_ptr = (g + 1) % R;
   endtask

   initial begin
      logic [R-1:0]  mask, exp_rdy;
      logic [BW-1:0] bsa, bsb;
      logic          exp_err;
      int            g;

      tbl[0]  = '{4'b1011, 4'd8,  4'd8, 4'b0001, 1'b0};
      tbl[1]  = '{4'b1011, 4'd8,  4'd8, 4'b0010, 1'b0};
      tbl[2]  = '{4'b1011, 4'd8,  4'd8, 4'b1000, 1'b0};
      tbl[3]  = '{4'b1011, 4'd8,  4'd8, 4'b0001, 1'b0};
      tbl[4]  = '{4'b0100, 4'd0,  4'd8, 4'b0100, 1'b1};
      tbl[5]  = '{4'b0100, 4'd8,  4'd9, 4'b0100, 1'b1};
      tbl[6]  = '{4'b0001, 4'd1,  4'd8, 4'b0001, 1'b0};
      tbl[7]  = '{4'b0011, 4'd8,  4'd8, 4'b0010, 1'b0};
      tbl[8]  = '{4'b1111, 4'd8,  4'd8, 4'b0100, 1'b0};
      tbl[9]  = '{4'b1111, 4'd0,  4'd0, 4'b1000, 1'b1};
      tbl[10] = '{4'b1001, 4'd15, 4'd3, 4'b0001, 1'b1};
      tbl[11] = '{4'b1110, 4'd4,  4'd4, 4'b0010, 1'b0};

      rst_ni = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = '0;
      mac_ready_i = 1'b0;
      mac_valid_i = 1'b0;
      mac_d_i = '0;
      req_a_i = '0;
      req_b_i = '0;
      req_c_i = '0;
      req_bsa_i = '0;
      req_bsb_i = '0;
      repeat (3) @(negedge clk_i);
      #1;
      check_reset_vals("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_reset_vals("post_reset");

      for (int i = 0; i < 12; i++) begin
         rand_ops();
         run_job(tbl[i].mask, tbl[i].bsa, tbl[i].bsb, tbl[i].rdy, tbl[i].err, i % 3, i % 2, i % 4);
      end

      // Requester 2: A=[[1,2],[3,4]], B=identity, C=0; MAC stalls 5 cycles, owner stalls 10.
      rand_ops();
      job_a[2] = 64'h0004_0003_0002_0001;
      job_b[2] = 64'h0001_0000_0000_0001;
      job_c[2] = '0;
      run_job(4'b0100, 4'd8, 4'd8, 4'b0100, 1'b0, 5, 2, 10);
      chk("single_job_d", rsp_d_o, 128'h00000004_00000003_00000002_00000001);

      rand_ops();
      job_c[1] = {4{32'd7}};
      run_job(4'b0010, 4'd0, 4'd8, 4'b0010, 1'b1, 0, 0, 3);
      chk("err_bsa_d", rsp_d_o, {4{32'd7}});
      rand_ops();
      job_c[1] = {4{32'd7}};
      run_job(4'b0010, 4'd8, BW'(BSMAX + 1), 4'b0010, 1'b1, 0, 0, 0);
      chk("err_bsb_d", rsp_d_o, {4{32'd7}});

      for (int t = 0; t < 24; t++) begin
         mask = R'($urandom_range(1, (1 << R) - 1));
         bsa = BW'($urandom_range(0, 9));
         bsb = BW'($urandom_range(0, 9));
         g = model_grant(mask, m_ptr);
         exp_rdy = R'(1 << g);
         exp_err = bs_illegal(bsa) || bs_illegal(bsb);
         rand_ops();
         run_job(mask, bsa, bsb, exp_rdy, exp_err,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset while the MAC owns a job: everything clears and the pointer restarts at 0.
      rand_ops();
      drive_ops(4'd8, 4'd8);
      req_valid_i = 4'b0010;
      #1;
      chk("rst_seq_grant", CW'(req_ready_o), CW'(4'b0010));
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = '0;
      mac_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      mac_ready_i = 1'b0;
      #1;
      chk("rst_seq_in_wait", CW'(mac_ready_o), CW'(1));
      rst_ni = 1'b0;
      #1;
      check_reset_vals("mid_wait");
      @(negedge clk_i);
      rst_ni = 1'b1;
      m_ptr = 0;
      rand_ops();
      run_job(4'b1111, 4'd8, 4'd8, 4'b0001, 1'b0, 1, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
